// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target register block: FSM state
// encoding, command-byte field positions, TCS3472 register map and the
// 8-bit address bytes for SLAVE_ADDR 0x29.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    CMD,
    CMD_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK
  } state_t;

  // Command byte: bit 7 marks a command; bits 6:5 select the transaction type.
  localparam int         CMD_BIT          = 7;
  localparam logic [1:0] CMD_TYPE_AUTOINC = 2'b01;

  // TCS3472 register addresses.
  localparam logic [7:0] REG_ENABLE = 8'h00;
  localparam logic [7:0] REG_CDATA  = 8'h14;
  localparam logic [7:0] REG_RDATA  = 8'h16;
  localparam logic [7:0] REG_GDATA  = 8'h18;
  localparam logic [7:0] REG_BDATA  = 8'h1A;

  // Address bytes as seen on the bus (7-bit address 0x29 plus R/W).
  localparam logic [7:0] ADDR_WRITE = 8'h52;
  localparam logic [7:0] ADDR_READ  = 8'h53;

endpackage

// File: rtl/i2c_bus_sync.sv
// Bus input conditioning for the I2C target.
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   scl_in, sda_in raw asynchronous bus lines
//   sda            synchronized SDA level
//   scl_rise/fall  one-clk pulses on synchronized SCL edges
//   start_det      SDA fell while SCL high
//   stop_det       SDA rose while SCL high
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  // [0] first sync stage, [1] synchronized level, [2] one-clk delayed level.
  logic [2:0] scl_sr;
  logic [2:0] sda_sr;

  // Reset to the idle bus level (both high) so release of reset never
  // fabricates an edge or a START/STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sr <= 3'b111;
      sda_sr <= 3'b111;
    end else begin
      scl_sr <= {scl_sr[1:0], scl_in};
      sda_sr <= {sda_sr[1:0], sda_in};
    end
  end

  assign sda       = sda_sr[1];
  assign scl_rise  =  scl_sr[1] & ~scl_sr[2];
  assign scl_fall  = ~scl_sr[1] &  scl_sr[2];
  assign start_det =  scl_sr[1] &  scl_sr[2] &  sda_sr[2] & ~sda_sr[1];
  assign stop_det  =  scl_sr[1] &  scl_sr[2] & ~sda_sr[2] &  sda_sr[1];

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target emulating the TCS3472 command/register protocol over a
// 2^REG_AW-entry, 8-bit register space. No clock stretching.
// Ports:
//   clk, rst          system clock (>= 20x SCL), asynchronous active-high reset
//   scl_in, sda_in    asynchronous bus inputs
//   sda_oe            1 = pull SDA low (open-drain pad)
//   reg_addr          register pointer
//   reg_rdata         combinational read data at reg_addr
//   reg_wdata, reg_we write data and one-clk write strobe
//   busy              high from START to STOP
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h29,
  parameter int         REG_AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic [REG_AW-1:0] reg_addr,
  input  logic [7:0]        reg_rdata,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              busy
);

  logic sda, scl_rise, scl_fall, start_det, stop_det;

  i2c_bus_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .sda       (sda),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        byte_done;  // 8 bits received, act on the next scl_fall
  logic        rw;
  logic        auto_inc;
  logic        mack;       // master's ACK bit after a read byte

  logic [REG_AW-1:0] inc;
  assign inc = {{(REG_AW-1){1'b0}}, auto_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd7;
      shift     <= 8'h00;
      byte_done <= 1'b0;
      rw        <= 1'b0;
      auto_inc  <= 1'b0;
      mack      <= 1'b1;
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= 8'h00;
      reg_we    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      reg_we <= 1'b0;
      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= 3'd7;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b1;
      end else if (stop_det) begin
        state     <= IDLE;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        if (scl_rise) begin
          case (state)
            ADDR, CMD, WDATA: begin
              shift <= {shift[6:0], sda};
              if (bit_cnt == 3'd0) byte_done <= 1'b1;
              else                 bit_cnt   <= bit_cnt - 3'd1;
            end
            RACK:    mack <= sda;
            default: ;
          endcase
        end
        if (scl_fall) begin
          case (state)
            ADDR: if (byte_done) begin
              byte_done <= 1'b0;
              bit_cnt   <= 3'd7;
              if (shift[7:1] == SLAVE_ADDR) begin
                rw     <= shift[0];
                sda_oe <= 1'b1;
                state  <= ADDR_ACK;
              end else begin
                state  <= IDLE;
              end
            end
            ADDR_ACK: begin
              if (!rw) begin
                sda_oe <= 1'b0;
                state  <= CMD;
              end else begin
                // Load samples the pointer before it advances.
                shift    <= reg_rdata;
                sda_oe   <= ~reg_rdata[7];
                bit_cnt  <= 3'd7;
                reg_addr <= reg_addr + inc;
                state    <= RDATA;
              end
            end
            CMD: if (byte_done) begin
              byte_done <= 1'b0;
              bit_cnt   <= 3'd7;
              if (shift[CMD_BIT]) begin
                sda_oe   <= 1'b1;
                reg_addr <= shift[REG_AW-1:0];
                auto_inc <= (shift[6:5] == CMD_TYPE_AUTOINC);
                state    <= CMD_ACK;
              end else begin
                sda_oe   <= 1'b0;
                state    <= IDLE;
              end
            end
            CMD_ACK: begin
              sda_oe <= 1'b0;
              state  <= WDATA;
            end
            WDATA: if (byte_done) begin
              byte_done <= 1'b0;
              bit_cnt   <= 3'd7;
              reg_we    <= 1'b1;
              reg_wdata <= shift;
              sda_oe    <= 1'b1;
              state     <= WDATA_ACK;
            end
            WDATA_ACK: begin
              sda_oe   <= 1'b0;
              reg_addr <= reg_addr + inc;
              state    <= WDATA;
            end
            RDATA: begin
              if (bit_cnt != 3'd0) begin
                shift   <= {shift[6:0], 1'b0};
                sda_oe  <= ~shift[6];
                bit_cnt <= bit_cnt - 3'd1;
              end else begin
                sda_oe  <= 1'b0;
                state   <= RACK;
              end
            end
            RACK: begin
              if (!mack) begin
                shift    <= reg_rdata;
                sda_oe   <= ~reg_rdata[7];
                bit_cnt  <= 3'd7;
                reg_addr <= reg_addr + inc;
                state    <= RDATA;
              end else begin
                sda_oe   <= 1'b0;
                state    <= IDLE;
              end
            end
            default: sda_oe <= 1'b0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Testbench for i2c_target_regs: bit-banged I2C master, wired-AND SDA,
// a register file behind the register port, and a reference model of the
// pointer / auto-increment rules plus expected register contents.
module tb_i2c_target_regs;
  import i2c_pkg::*;

  localparam int Q = 6;  // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl = 1'b1;
  logic sda_m = 1'b1;
  logic sda_oe, reg_we, busy;
  logic [4:0] reg_addr;
  logic [7:0] reg_rdata, reg_wdata;
  wire sda_bus = sda_m & ~sda_oe;

  logic [7:0] mem [32];
  logic       preload = 1'b1;
  int         we_cnt = 0;
  int         oe_cnt = 0;
  logic [4:0] last_we_addr = 5'h0;
  logic [7:0] last_we_data = 8'h0;

  logic [7:0] ref_mem [32];
  int         m_ptr;
  bit         m_ainc;
  logic [7:0] wbuf [8];
  logic [7:0] rbuf [8];

  int checks = 0;
  int errors = 0;

  i2c_target_regs dut (
    .clk       (clk),
    .rst       (rst),
    .scl_in    (scl),
    .sda_in    (sda_bus),
    .sda_oe    (sda_oe),
    .reg_addr  (reg_addr),
    .reg_rdata (reg_rdata),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign reg_rdata = mem[reg_addr];

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'(i * 37 + 11);
    end else if (reg_we) begin
      mem[reg_addr] <= reg_wdata;
    end
    if (reg_we) begin
      we_cnt       <= we_cnt + 1;
      last_we_addr <= reg_addr;
      last_we_data <= reg_wdata;
    end
    if (sda_oe) oe_cnt <= oe_cnt + 1;
  end

  initial begin
    #900us;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic hq();
    repeat (Q) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; scl = 1'b1; hq();
    sda_m = 1'b0; hq();
    scl = 1'b0; hq();
  endtask

  task automatic bus_rstart();
    sda_m = 1'b1; hq();
    scl = 1'b1; hq();
    sda_m = 1'b0; hq();
    scl = 1'b0; hq();
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; hq();
    scl = 1'b1; hq();
    sda_m = 1'b1; hq();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; hq();
    scl = 1'b1; hq(); hq();
    scl = 1'b0; hq();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; hq();
    scl = 1'b1; hq();
    b = sda_bus; hq();
    scl = 1'b0; hq();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
  endtask

  // Address + command + n data bytes from wbuf; leaves the bus mid-transaction.
  task automatic txn_write(input logic [7:0] cmd, input int n);
    logic ack;
    int c0;
    bus_start();
    write_byte(ADDR_WRITE, ack);
    check("w_addr_ack", 32'(ack), 0);
    write_byte(cmd, ack);
    check("w_cmd_ack", 32'(ack), 0);
    m_ptr  = int'(cmd[4:0]);
    m_ainc = (cmd[6:5] == 2'b01);
    for (int i = 0; i < n; i++) begin
      c0 = we_cnt;
      write_byte(wbuf[i], ack);
      check("w_data_ack", 32'(ack), 0);
      check("we_count", we_cnt - c0, 1);
      check("we_addr", 32'(last_we_addr), m_ptr);
      check("we_data", 32'(last_we_data), 32'(wbuf[i]));
      ref_mem[m_ptr] = wbuf[i];
      if (m_ainc) m_ptr = (m_ptr + 1) % 32;
    end
  endtask

  // Read n bytes (ACK all but the last), then STOP.
  task automatic txn_read(input int n, input bit rstart);
    logic ack;
    if (rstart) bus_rstart(); else bus_start();
    write_byte(ADDR_READ, ack);
    check("r_addr_ack", 32'(ack), 0);
    for (int i = 0; i < n; i++) begin
      read_byte(rbuf[i], (i == n - 1));
      check("r_data", 32'(rbuf[i]), 32'(ref_mem[m_ptr]));
      if (m_ainc) m_ptr = (m_ptr + 1) % 32;
    end
    check("r_release", 32'(sda_oe), 0);
    bus_stop();
    hq();
    check("r_ptr", 32'(reg_addr), m_ptr);
    check("r_busy", 32'(busy), 0);
  endtask

  initial begin
    logic ack;
    int c0, o0, n;
    logic [7:0] cmd;

    for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i * 37 + 11);
    m_ptr = 0;
    m_ainc = 1'b0;

    repeat (4) @(negedge clk);
    check("rst_sda_oe", 32'(sda_oe), 0);
    preload = 1'b0;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_reg_we", 32'(reg_we), 0);
    check("rst_wdata", 32'(reg_wdata), 0);
    check("rst_addr", 32'(reg_addr), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_oe_idle", 32'(sda_oe), 0);

    // 1: single register write
    wbuf[0] = 8'h03;
    txn_write(8'h80, 1);
    check("t1_busy_hi", 32'(busy), 1);
    bus_stop(); hq();
    check("t1_busy_lo", 32'(busy), 0);
    check("t1_we_addr", 32'(last_we_addr), 32'h00);
    check("t1_we_data", 32'(last_we_data), 32'h03);

    // 2: wrong address is ignored
    c0 = we_cnt; o0 = oe_cnt;
    bus_start();
    write_byte(8'h54, ack); check("t2_nack_addr", 32'(ack), 1);
    write_byte(8'h80, ack); check("t2_nack_d0", 32'(ack), 1);
    write_byte(8'h03, ack); check("t2_nack_d1", 32'(ack), 1);
    bus_stop(); hq();
    check("t2_no_oe", oe_cnt - o0, 0);
    check("t2_no_we", we_cnt - c0, 0);

    // 3: write 0x16/0x17, then set pointer, repeated START, read two bytes
    wbuf[0] = 8'hA5; wbuf[1] = 8'h3C;
    txn_write(8'hB6, 2);
    bus_stop();
    txn_write(8'hB6, 0);
    txn_read(2, 1'b1);
    check("t3_byte0", 32'(rbuf[0]), 32'hA5);
    check("t3_byte1", 32'(rbuf[1]), 32'h3C);
    check("t3_ptr", 32'(reg_addr), 32'h18);

    // 4: command without bit 7 is NACKed
    c0 = we_cnt;
    bus_start();
    write_byte(ADDR_WRITE, ack); check("t4_addr_ack", 32'(ack), 0);
    write_byte(8'h16, ack);      check("t4_cmd_nack", 32'(ack), 1);
    bus_stop(); hq();
    check("t4_ptr", 32'(reg_addr), m_ptr);
    check("t4_no_we", we_cnt - c0, 0);

    // 5: auto-increment wraps 0x1F -> 0x00
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    txn_write(8'hBF, 2);
    bus_stop(); hq();
    check("t5_wrap_addr", 32'(last_we_addr), 32'h00);
    check("t5_ptr", 32'(reg_addr), 32'h01);

    // Randomized writes and pointer-retaining reads
    for (int t = 0; t < 16; t++) begin
      n = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom);
        cmd = {1'b1, 2'($urandom_range(0, 3)), 5'($urandom)};
        txn_write(cmd, n);
        bus_stop(); hq();
        check("rnd_w_ptr", 32'(reg_addr), m_ptr);
      end else begin
        txn_read(n, 1'b0);
      end
    end

    // 6: reset while driving a 0 read bit
    wbuf[0] = 8'h12;
    txn_write(8'h85, 1);
    bus_stop();
    bus_start();
    write_byte(ADDR_READ, ack);
    check("t6_addr_ack", 32'(ack), 0);
    hq();
    check("t6_drive0", 32'(sda_oe), 1);
    #3 rst = 1'b1;
    #1 check("t6_async_rst", 32'(sda_oe), 0);
    scl = 1'b1; sda_m = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    m_ptr = 0; m_ainc = 1'b0;
    check("t6_rst_ptr", 32'(reg_addr), 0);
    check("t6_rst_busy", 32'(busy), 0);
    txn_read(1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
